// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer: op codes, FSM states
// and small op-decode helpers.
package hilo_muldiv_ctrl_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } md_state_t;

  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic md_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// EX-stage <-> mul/div sequencer bundle: operation request, flush, stall and the
// HI/LO result strobe.
interface hilo_muldiv_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              op_valid;
  logic [1:0]        op_code;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              flush;
  logic              stall_o;
  logic              busy;
  logic              res_valid;
  logic [DATA_W-1:0] res_hi;
  logic [DATA_W-1:0] res_lo;

  modport master (
    output op_valid, op_code, src_a, src_b, flush,
    input  stall_o, busy, res_valid, res_hi, res_lo
  );

  modport slave (
    input  op_valid, op_code, src_a, src_b, flush,
    output stall_o, busy, res_valid, res_hi, res_lo
  );
endinterface

// File: rtl/muldiv_div_core.sv
// Radix-2 restoring divider datapath on unsigned magnitudes. step_quo/step_rem are
// the values after the current step, so the controller can take the last one directly.
module muldiv_div_core #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic              en,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] step_quo,
  output logic [DATA_W-1:0] step_rem
);

  logic [DATA_W-1:0] rem_reg;
  logic [DATA_W-1:0] quo_reg;
  logic [DATA_W-1:0] dsr_reg;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   diff;

  // quo_reg starts as the dividend; its MSB feeds the partial remainder each step
  // while quotient bits enter at the LSB.
  always_comb begin
    shifted = {rem_reg, quo_reg[DATA_W-1]};
    diff    = shifted - {1'b0, dsr_reg};
    if (!diff[DATA_W]) begin
      step_rem = diff[DATA_W-1:0];
      step_quo = {quo_reg[DATA_W-2:0], 1'b1};
    end else begin
      step_rem = shifted[DATA_W-1:0];
      step_quo = {quo_reg[DATA_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_reg <= '0;
      quo_reg <= '0;
      dsr_reg <= '0;
    end else if (load) begin
      rem_reg <= '0;
      quo_reg <= dividend;
      dsr_reg <= divisor;
    end else if (en) begin
      rem_reg <= step_rem;
      quo_reg <= step_quo;
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// MULT/MULTU/DIV/DIVU sequencer producing {HI,LO} with a one-cycle write strobe.
// Optional DIV_ZERO_FAST_EN: divide by zero completes in one cycle.
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 2
) (
  input logic               clk,
  input logic               resetn,
  hilo_muldiv_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W);

  md_state_t           state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg;
  logic                mul_signed_reg;
  logic [DATA_W-1:0]   a_reg, b_reg;
  logic [DATA_W-1:0]   res_hi_reg, res_lo_reg;
  logic                neg_q_reg, neg_r_reg;

  logic                accept, fast_zero, cnt_zero, in_mul, in_div;
  logic                signed_op, is_div;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [DATA_W-1:0]   step_quo, step_rem, quo_fix, rem_fix;
  logic [2*DATA_W-1:0] mul_a_ext, mul_b_ext, product;

  assign signed_op = md_is_signed(bus.op_code);
  assign is_div    = md_is_div(bus.op_code);
  assign in_mul    = (state_reg == ST_MUL);
  assign in_div    = (state_reg == ST_DIV);
  assign cnt_zero  = (cnt_reg == '0);
  assign accept    = (state_reg == ST_IDLE) & bus.op_valid & ~bus.flush;

`ifdef DIV_ZERO_FAST_EN
  assign fast_zero = is_div && (bus.src_b == '0);
`else
  assign fast_zero = 1'b0;
`endif

  assign a_mag = (signed_op & bus.src_a[DATA_W-1]) ? -bus.src_a : bus.src_a;
  assign b_mag = (signed_op & bus.src_b[DATA_W-1]) ? -bus.src_b : bus.src_b;

  // Sign-extending to 2*DATA_W makes a single unsigned multiply correct for MULT too.
  assign mul_a_ext = {{DATA_W{mul_signed_reg & a_reg[DATA_W-1]}}, a_reg};
  assign mul_b_ext = {{DATA_W{mul_signed_reg & b_reg[DATA_W-1]}}, b_reg};
  assign product   = mul_a_ext * mul_b_ext;

  assign quo_fix = neg_q_reg ? -step_quo : step_quo;
  assign rem_fix = neg_r_reg ? -step_rem : step_rem;

  muldiv_div_core #(
    .DATA_W(DATA_W)
  ) u_div_core (
    .clk      (clk),
    .resetn   (resetn),
    .load     (accept),
    .en       (in_div & ~bus.flush),
    .dividend (a_mag),
    .divisor  (b_mag),
    .step_quo (step_quo),
    .step_rem (step_rem)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (bus.flush) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: if (bus.op_valid) begin
          if (fast_zero)   state_next = ST_DONE;
          else if (is_div) state_next = ST_DIV;
          else             state_next = ST_MUL;
        end
        ST_MUL:  if (cnt_zero) state_next = ST_DONE;
        ST_DIV:  if (cnt_zero) state_next = ST_DONE;
        ST_DONE: state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.stall_o   = accept | in_mul | in_div;
    bus.busy      = (state_reg != ST_IDLE);
    bus.res_valid = (state_reg == ST_DONE) & ~bus.flush;
    bus.res_hi    = res_hi_reg;
    bus.res_lo    = res_lo_reg;
  end

  // HI/LO only move on the edge into DONE, so a flushed op leaves them untouched.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_reg        <= '0;
      mul_signed_reg <= 1'b0;
      a_reg          <= '0;
      b_reg          <= '0;
      neg_q_reg      <= 1'b0;
      neg_r_reg      <= 1'b0;
      res_hi_reg     <= '0;
      res_lo_reg     <= '0;
    end else if (accept) begin
      mul_signed_reg <= signed_op;
      a_reg          <= bus.src_a;
      b_reg          <= bus.src_b;
      cnt_reg        <= is_div ? CNT_W'(DATA_W - 1) : CNT_W'(MUL_LAT - 1);
      neg_q_reg      <= signed_op & (bus.src_a[DATA_W-1] ^ bus.src_b[DATA_W-1]);
      neg_r_reg      <= signed_op & bus.src_a[DATA_W-1];
      if (fast_zero) begin
        res_hi_reg <= bus.src_a;
        res_lo_reg <= '1;
      end
    end else if (!bus.flush && (in_mul || in_div)) begin
      if (!cnt_zero) begin
        cnt_reg <= cnt_reg - CNT_W'(1);
      end else if (in_mul) begin
        {res_hi_reg, res_lo_reg} <= product;
      end else begin
        res_hi_reg <= rem_fix;
        res_lo_reg <= quo_fix;
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: table of mul/div vectors plus flush and
// mid-op reset sequences. Honours DIV_ZERO_FAST_EN when defined.
module tb_hilo_muldiv_ctrl;
  import hilo_muldiv_ctrl_pkg::*;

  logic clk;
  logic resetn;

  hilo_muldiv_ctrl_if #(.DATA_W(32)) bus ();

  hilo_muldiv_ctrl #(.DATA_W(32), .MUL_LAT(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  int n_cmp = 0;
  int n_err = 0;
  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    logic [63:0] prev;
    int stalls, got;
    bit held;
    @(negedge clk);
    prev = {bus.res_hi, bus.res_lo};
    bus.op_valid = 1'b1;
    bus.op_code  = v.op;
    bus.src_a    = v.a;
    bus.src_b    = v.b;
    stalls = 0;
    got    = -1;
    held   = 1'b1;
    for (int c = 0; c < 80; c++) begin
      #1;
      if (bus.res_valid) begin
        got = c;
        break;
      end
      if (bus.stall_o) stalls++;
      if ({bus.res_hi, bus.res_lo} !== prev) held = 1'b0;
      @(negedge clk);
    end
    bus.op_valid = 1'b0;
    if (got < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s timeout: no res_valid within 80 cycles", v.name);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      return;
    end
    $display("%s a=%h b=%h -> hi=%h lo=%h at cycle %0d", v.name, v.a, v.b, bus.res_hi, bus.res_lo, got);
    chk({v.name, " latency"}, 64'(got), 64'(v.lat));
    chk({v.name, " stall_cycles"}, 64'(stalls), 64'(v.lat));
    chk({v.name, " stall_in_done"}, 64'(bus.stall_o), 64'(0));
    chk({v.name, " hilo_held"}, 64'(held), 64'(1));
    chk({v.name, " hi"}, 64'(bus.res_hi), 64'(v.hi));
    chk({v.name, " lo"}, 64'(bus.res_lo), 64'(v.lo));
  endtask

  initial begin
    logic [63:0] prev;
    bit seen;
    vec_t v;

    vecs[0]  = '{"MULT -3*5",        MD_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 3};
    vecs[1]  = '{"MULTU ffffffff*2", MD_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 3};
    vecs[2]  = '{"MULT -1*-1",       MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 3};
    vecs[3]  = '{"MULTU max*max",    MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 3};
    vecs[4]  = '{"MULT min*min",     MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 3};
    vecs[5]  = '{"DIVU 100/7",       MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       33};
    vecs[6]  = '{"DIV -7/2",         MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[7]  = '{"DIV 7/-2",         MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
    vecs[8]  = '{"DIV -7/-2",        MD_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 33};
    vecs[9]  = '{"DIVU 9/0",         MD_DIVU,  32'd9,        32'd0,        32'd9,        32'hFFFFFFFF, ZLAT};
`ifdef DIV_ZERO_FAST_EN
    vecs[10] = '{"DIV -7/0",         MD_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, ZLAT};
`else
    vecs[10] = '{"DIV -7/0",         MD_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'h00000001, ZLAT};
`endif
    vecs[11] = '{"DIVU max/1",       MD_DIVU,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 33};
    vecs[12] = '{"DIV min/-1",       MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
    vecs[13] = '{"DIVU 5/10",        MD_DIVU,  32'd5,        32'd10,       32'd5,        32'd0,        33};

    resetn       = 1'b0;
    bus.op_valid = 1'b0;
    bus.op_code  = 2'b00;
    bus.src_a    = '0;
    bus.src_b    = '0;
    bus.flush    = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset stall_o",   64'(bus.stall_o),   64'(0));
    chk("reset busy",      64'(bus.busy),      64'(0));
    chk("reset res_valid", 64'(bus.res_valid), 64'(0));
    chk("reset hilo",      {bus.res_hi, bus.res_lo}, 64'(0));
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 14; i++) run_op(vecs[i]);

    // Flush during a divide at cycle 10: no strobe, HI/LO keep the last result.
    @(negedge clk);
    prev = {bus.res_hi, bus.res_lo};
    bus.op_valid = 1'b1;
    bus.op_code  = MD_DIVU;
    bus.src_a    = 32'd1000;
    bus.src_b    = 32'd3;
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    #1;
    chk("flush res_valid", 64'(bus.res_valid), 64'(0));
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.op_valid = 1'b0;
    #1;
    chk("flush busy",  64'(bus.busy),    64'(0));
    chk("flush stall", 64'(bus.stall_o), 64'(0));
    chk("flush hilo",  {bus.res_hi, bus.res_lo}, prev);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (bus.res_valid) seen = 1'b1;
    end
    chk("flush no strobe", 64'(seen), 64'(0));
    $display("flush during DIVU: busy=%0d hi=%h lo=%h", bus.busy, bus.res_hi, bus.res_lo);

    // Flush in IDLE blocks the accept.
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_code  = MD_MULT;
    bus.flush    = 1'b1;
    #1;
    chk("idle flush stall", 64'(bus.stall_o), 64'(0));
    @(negedge clk);
    bus.op_valid = 1'b0;
    bus.flush    = 1'b0;
    #1;
    chk("idle flush busy", 64'(bus.busy), 64'(0));
    $display("flush in IDLE: busy=%0d", bus.busy);

    run_op(vecs[1]);

    // Flush in DONE: result already written, but no strobe.
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_code  = MD_MULT;
    bus.src_a    = 32'hFFFFFFFD;
    bus.src_b    = 32'd5;
    repeat (3) @(negedge clk);
    bus.flush = 1'b1;
    #1;
    chk("done flush res_valid", 64'(bus.res_valid), 64'(0));
    chk("done flush hilo", {bus.res_hi, bus.res_lo}, 64'hFFFFFFFF_FFFFFFF1);
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.op_valid = 1'b0;
    #1;
    chk("done flush busy", 64'(bus.busy), 64'(0));
    $display("flush in DONE: hi=%h lo=%h", bus.res_hi, bus.res_lo);

    // Reset pulsed at cycle 5 of a divide.
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_code  = MD_DIV;
    bus.src_a    = 32'hFFFFFFF9;
    bus.src_b    = 32'd2;
    repeat (5) @(negedge clk);
    resetn       = 1'b0;
    bus.op_valid = 1'b0;
    #1;
    chk("midreset outputs",
        {59'(0), bus.stall_o, bus.busy, bus.res_valid, 2'b00} | 64'(bus.res_hi) | 64'(bus.res_lo),
        64'(0));
    chk("midreset hilo", {bus.res_hi, bus.res_lo}, 64'(0));
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    #1;
    chk("post reset busy", 64'(bus.busy), 64'(0));
    $display("reset mid-DIV: busy=%0d hi=%h lo=%h", bus.busy, bus.res_hi, bus.res_lo);

    v = vecs[6];
    run_op(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
